// File: rtl/butterfly_mem_arbiter_if.sv
// Bundles the fetch port, the data port and the shared memory bus of butterfly_mem_arbiter.
// The slave modport is the arbiter's view; master is the surrounding core/memory side.
interface butterfly_mem_arbiter_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              imem_valid_i;
  logic [ADDR_W-1:0] imem_addr_i;
  logic [DATA_W-1:0] imem_rdata_o;
  logic              imem_ready_o;
  logic              imem_err_o;

  logic              dmem_valid_i;
  logic              dmem_write_i;
  logic [ADDR_W-1:0] dmem_addr_i;
  logic [DATA_W-1:0] dmem_wdata_i;
  logic [STRB_W-1:0] dmem_wstrb_i;
  logic [DATA_W-1:0] dmem_rdata_o;
  logic              dmem_ready_o;
  logic              dmem_err_o;

  logic              mem_valid_o;
  logic              mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [STRB_W-1:0] mem_wstrb_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_ready_i;

  modport slave (
    input  imem_valid_i, imem_addr_i,
    output imem_rdata_o, imem_ready_o, imem_err_o,
    input  dmem_valid_i, dmem_write_i, dmem_addr_i, dmem_wdata_i, dmem_wstrb_i,
    output dmem_rdata_o, dmem_ready_o, dmem_err_o,
    output mem_valid_o, mem_write_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
    input  mem_rdata_i, mem_ready_i
  );

  modport master (
    output imem_valid_i, imem_addr_i,
    input  imem_rdata_o, imem_ready_o, imem_err_o,
    output dmem_valid_i, dmem_write_i, dmem_addr_i, dmem_wdata_i, dmem_wstrb_i,
    input  dmem_rdata_o, dmem_ready_o, dmem_err_o,
    input  mem_valid_o, mem_write_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
    output mem_rdata_i, mem_ready_i
  );
endinterface

// File: rtl/butterfly_mem_arbiter.sv
// Fetch/data to single memory bus arbiter with bounded-starvation priority and ready timeout.
// Define BUTTERFLY_ARB_RR_EN to replace data priority with round-robin on ties.
module butterfly_mem_arbiter #(
  parameter int unsigned MAX_STARVE     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input logic                    clk_i,
  input logic                    rst_i,
  butterfly_mem_arbiter_if.slave bus
);
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned STRB_W   = 4;
  localparam int unsigned TO_W     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  if (MAX_STARVE == 0 || MAX_STARVE > 15) begin : g_bad_max_starve
    $error("butterfly_mem_arbiter: MAX_STARVE must be in 1..15");
  end

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t            state;
  logic [TO_W-1:0]   to_cnt;
  logic              mem_valid_q;
  logic              mem_write_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [STRB_W-1:0] mem_wstrb_q;

  logic pick_d_c;
  logic grant_d_c;
  logic grant_i_c;
  logic busy_c;
  logic timeout_c;
  logic done_c;

`ifdef BUTTERFLY_ARB_RR_EN
  // Set when data held the most recent grant; ties go to the other requester.
  logic last_d;
  assign pick_d_c = bus.dmem_valid_i && (!bus.imem_valid_i || !last_d);
`else
  localparam int unsigned STARVE_W = 4;
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(MAX_STARVE);
  logic [STARVE_W-1:0] starve_cnt;
  assign pick_d_c = bus.dmem_valid_i && (!bus.imem_valid_i || (starve_cnt != STARVE_MAX));
`endif

  assign grant_d_c = (state == IDLE) && pick_d_c;
  assign grant_i_c = (state == IDLE) && !pick_d_c && bus.imem_valid_i;
  assign busy_c    = (state == BUSY_I) || (state == BUSY_D);

  // A real ready in the timeout cycle takes precedence over the abort.
  assign timeout_c = busy_c && !bus.mem_ready_i && (TIMEOUT_CYCLES != 0) && (to_cnt == TO_LAST);
  assign done_c    = busy_c && (bus.mem_ready_i || timeout_c);

  assign bus.imem_ready_o = (state == BUSY_I) && done_c;
  assign bus.imem_err_o   = (state == BUSY_I) && timeout_c;
  assign bus.imem_rdata_o = ((state == BUSY_I) && bus.mem_ready_i) ? bus.mem_rdata_i : '0;
  assign bus.dmem_ready_o = (state == BUSY_D) && done_c;
  assign bus.dmem_err_o   = (state == BUSY_D) && timeout_c;
  assign bus.dmem_rdata_o = ((state == BUSY_D) && bus.mem_ready_i) ? bus.mem_rdata_i : '0;

  assign bus.mem_valid_o = mem_valid_q;
  assign bus.mem_write_o = mem_write_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.mem_wstrb_o = mem_wstrb_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      to_cnt      <= '0;
      mem_valid_q <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
`ifdef BUTTERFLY_ARB_RR_EN
      last_d      <= 1'b0;
`else
      starve_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          to_cnt <= '0;
          if (grant_d_c) begin
            state       <= BUSY_D;
            mem_valid_q <= 1'b1;
            mem_write_q <= bus.dmem_write_i;
            mem_addr_q  <= bus.dmem_addr_i;
            mem_wdata_q <= bus.dmem_wdata_i;
            mem_wstrb_q <= bus.dmem_wstrb_i;
          end else if (grant_i_c) begin
            state       <= BUSY_I;
            mem_valid_q <= 1'b1;
            mem_write_q <= 1'b0;
            mem_addr_q  <= bus.imem_addr_i;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (done_c) begin
            state       <= IDLE;
            mem_valid_q <= 1'b0;
          end else if (TIMEOUT_CYCLES != 0) begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase

`ifdef BUTTERFLY_ARB_RR_EN
      if (grant_d_c) begin
        last_d <= 1'b1;
      end else if (grant_i_c) begin
        last_d <= 1'b0;
      end
`else
      // Starvation count only moves in IDLE, where the fetch port is sampled.
      if (state == IDLE) begin
        if (!bus.imem_valid_i || grant_i_c) begin
          starve_cnt <= '0;
        end else if (grant_d_c && (starve_cnt != STARVE_MAX)) begin
          starve_cnt <= starve_cnt + STARVE_W'(1);
        end
      end
`endif
    end
  end
endmodule

// File: tb/tb_butterfly_mem_arbiter.sv
// Directed bench for butterfly_mem_arbiter (MAX_STARVE=4, TIMEOUT_CYCLES=8).
module tb_butterfly_mem_arbiter;
  logic clk_i = 1'b0;
  logic rst_i;
  int   errors = 0;
  int   checks = 0;

  butterfly_mem_arbiter_if bus();

  butterfly_mem_arbiter #(
    .MAX_STARVE    (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic idle_inputs();
    bus.imem_valid_i = 1'b0;
    bus.imem_addr_i  = '0;
    bus.dmem_valid_i = 1'b0;
    bus.dmem_write_i = 1'b0;
    bus.dmem_addr_i  = '0;
    bus.dmem_wdata_i = '0;
    bus.dmem_wstrb_i = '0;
    bus.mem_rdata_i  = '0;
    bus.mem_ready_i  = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk_i);
    #1;
    checks++;
    if ({bus.mem_valid_o, bus.mem_write_o, bus.mem_wstrb_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 000000", {bus.mem_valid_o, bus.mem_write_o, bus.mem_wstrb_o});
    end
    checks++;
    if ({bus.mem_addr_o, bus.mem_wdata_o} !== 64'h0) begin
      errors++;
      $display("FAIL reset_bus: got %h want 0", {bus.mem_addr_o, bus.mem_wdata_o});
    end
    checks++;
    if ({bus.imem_ready_o, bus.imem_err_o, bus.dmem_ready_o, bus.dmem_err_o,
         bus.imem_rdata_o, bus.dmem_rdata_o} !== 68'h0) begin
      errors++;
      $display("FAIL reset_resp: got %h want 0", {bus.imem_ready_o, bus.imem_err_o,
               bus.dmem_ready_o, bus.dmem_err_o, bus.imem_rdata_o, bus.dmem_rdata_o});
    end
    rst_i = 1'b0;
  endtask

  task automatic test_single_fetch();
    @(negedge clk_i);
    bus.imem_valid_i = 1'b1;
    bus.imem_addr_i  = 32'h0000_0100;
    @(negedge clk_i);
    #1;
    checks++;
    if ({bus.mem_valid_o, bus.mem_write_o, bus.mem_wstrb_o, bus.mem_addr_o, bus.imem_ready_o} !==
        {1'b1, 1'b0, 4'b0000, 32'h0000_0100, 1'b0}) begin
      errors++;
      $display("FAIL fetch_grant: got %h want %h",
               {bus.mem_valid_o, bus.mem_write_o, bus.mem_wstrb_o, bus.mem_addr_o, bus.imem_ready_o},
               {1'b1, 1'b0, 4'b0000, 32'h0000_0100, 1'b0});
    end
    @(negedge clk_i);
    bus.mem_ready_i = 1'b1;
    bus.mem_rdata_i = 32'h0000_0013;
    #1;
    checks++;
    if ({bus.imem_ready_o, bus.imem_err_o, bus.imem_rdata_o, bus.dmem_ready_o} !==
        {1'b1, 1'b0, 32'h0000_0013, 1'b0}) begin
      errors++;
      $display("FAIL fetch_resp: got %h want %h",
               {bus.imem_ready_o, bus.imem_err_o, bus.imem_rdata_o, bus.dmem_ready_o},
               {1'b1, 1'b0, 32'h0000_0013, 1'b0});
    end
    @(negedge clk_i);
    idle_inputs();
    #1;
    checks++;
    if ({bus.mem_valid_o, bus.imem_ready_o} !== 2'b00) begin
      errors++;
      $display("FAIL fetch_done: got %b want 00", {bus.mem_valid_o, bus.imem_ready_o});
    end
  endtask

  task automatic test_store();
    @(negedge clk_i);
    bus.dmem_valid_i = 1'b1;
    bus.dmem_write_i = 1'b1;
    bus.dmem_addr_i  = 32'h2000_0004;
    bus.dmem_wdata_i = 32'hDEAD_BEEF;
    bus.dmem_wstrb_i = 4'b0011;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      #1;
      checks++;
      if ({bus.mem_valid_o, bus.mem_write_o, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_wstrb_o,
           bus.dmem_ready_o} !== {1'b1, 1'b1, 32'h2000_0004, 32'hDEAD_BEEF, 4'b0011, 1'b0}) begin
        errors++;
        $display("FAIL store_payload_c%0d: got %h want %h", c,
                 {bus.mem_valid_o, bus.mem_write_o, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_wstrb_o,
                  bus.dmem_ready_o}, {1'b1, 1'b1, 32'h2000_0004, 32'hDEAD_BEEF, 4'b0011, 1'b0});
      end
    end
    @(negedge clk_i);
    bus.mem_ready_i = 1'b1;
    #1;
    checks++;
    if ({bus.dmem_ready_o, bus.dmem_err_o, bus.imem_ready_o} !== 3'b100) begin
      errors++;
      $display("FAIL store_resp: got %b want 100", {bus.dmem_ready_o, bus.dmem_err_o, bus.imem_ready_o});
    end
    @(negedge clk_i);
    idle_inputs();
    #1;
    checks++;
    if ({bus.mem_valid_o, bus.dmem_ready_o} !== 2'b00) begin
      errors++;
      $display("FAIL store_pulse: got %b want 00", {bus.mem_valid_o, bus.dmem_ready_o});
    end
  endtask

  task automatic test_contention();
    bit exp_d [10];
    int n = 0;
    int cyc = 0;
    int last_cyc = 0;
    logic got_d;
`ifdef BUTTERFLY_ARB_RR_EN
    exp_d = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`endif
    @(negedge clk_i);
    bus.imem_valid_i = 1'b1;
    bus.imem_addr_i  = 32'h0000_1000;
    bus.dmem_valid_i = 1'b1;
    bus.dmem_write_i = 1'b0;
    bus.dmem_addr_i  = 32'h0000_2000;
    bus.dmem_wstrb_i = 4'b0000;
    while (n < 10 && cyc < 100) begin
      @(negedge clk_i);
      bus.mem_ready_i = 1'b0;
      cyc++;
      #1;
      if (bus.mem_valid_o === 1'b1) begin
        got_d = (bus.mem_addr_o == 32'h0000_2000);
        checks++;
        if (got_d !== exp_d[n]) begin
          errors++;
          $display("FAIL contention_order_%0d: got data=%b want data=%b", n, got_d, exp_d[n]);
        end
        if (n > 0) begin
          checks++;
          if (cyc - last_cyc != 2) begin
            errors++;
            $display("FAIL contention_gap_%0d: got %0d want 2", n, cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        bus.mem_ready_i = 1'b1;
        bus.mem_rdata_i = 32'h0000_0100 + n;
        #1;
        checks++;
        if ({bus.dmem_ready_o, bus.imem_ready_o} !== (exp_d[n] ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL contention_ready_%0d: got %b want %b", n,
                   {bus.dmem_ready_o, bus.imem_ready_o}, (exp_d[n] ? 2'b10 : 2'b01));
        end
        n++;
      end
    end
    checks++;
    if (n != 10) begin
      errors++;
      $display("FAIL contention_budget: got %0d grants want 10", n);
    end
    @(negedge clk_i);
    idle_inputs();
    @(negedge clk_i);
  endtask

  task automatic test_timeout();
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk_i);
      bus.dmem_valid_i = 1'b1;
      bus.dmem_write_i = 1'b0;
      bus.dmem_addr_i  = 32'h0000_3000;
      bus.mem_rdata_i  = 32'hA5A5_A5A5;
      bus.mem_ready_i  = 1'b0;
      for (int b = 1; b <= 8; b++) begin
        @(negedge clk_i);
        if (b == 8 && pass == 1) begin
          bus.mem_ready_i = 1'b1;
          bus.mem_rdata_i = 32'h0000_0055;
        end
        #1;
        if (b < 8) begin
          checks++;
          if ({bus.mem_valid_o, bus.dmem_ready_o, bus.dmem_err_o} !== 3'b100) begin
            errors++;
            $display("FAIL timeout_wait_p%0d_b%0d: got %b want 100", pass, b,
                     {bus.mem_valid_o, bus.dmem_ready_o, bus.dmem_err_o});
          end
        end else if (pass == 0) begin
          checks++;
          if ({bus.dmem_ready_o, bus.dmem_err_o, bus.dmem_rdata_o} !== {1'b1, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL timeout_abort: got %h want %h",
                     {bus.dmem_ready_o, bus.dmem_err_o, bus.dmem_rdata_o}, {1'b1, 1'b1, 32'h0});
          end
        end else begin
          checks++;
          if ({bus.dmem_ready_o, bus.dmem_err_o, bus.dmem_rdata_o} !== {1'b1, 1'b0, 32'h0000_0055}) begin
            errors++;
            $display("FAIL timeout_ready_wins: got %h want %h",
                     {bus.dmem_ready_o, bus.dmem_err_o, bus.dmem_rdata_o}, {1'b1, 1'b0, 32'h0000_0055});
          end
        end
      end
      @(negedge clk_i);
      idle_inputs();
      #1;
      checks++;
      if ({bus.mem_valid_o, bus.dmem_ready_o} !== 2'b00) begin
        errors++;
        $display("FAIL timeout_drop_p%0d: got %b want 00", pass, {bus.mem_valid_o, bus.dmem_ready_o});
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk_i);
    bus.dmem_valid_i = 1'b1;
    bus.dmem_write_i = 1'b1;
    bus.dmem_addr_i  = 32'h0000_4000;
    bus.dmem_wdata_i = 32'h1234_5678;
    bus.dmem_wstrb_i = 4'b1111;
    @(negedge clk_i);
    #1;
    checks++;
    if (bus.mem_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_busy: got %b want 1", bus.mem_valid_o);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    idle_inputs();
    bus.mem_ready_i = 1'b1;
    bus.mem_rdata_i = 32'hFFFF_FFFF;
    #1;
    checks++;
    if ({bus.mem_valid_o, bus.mem_write_o, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_wstrb_o} !== 70'h0) begin
      errors++;
      $display("FAIL rstmid_bus: got %h want 0",
               {bus.mem_valid_o, bus.mem_write_o, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_wstrb_o});
    end
    checks++;
    if ({bus.imem_ready_o, bus.imem_err_o, bus.dmem_ready_o, bus.dmem_err_o,
         bus.imem_rdata_o, bus.dmem_rdata_o} !== 68'h0) begin
      errors++;
      $display("FAIL rstmid_stale_ready: got %h want 0", {bus.imem_ready_o, bus.imem_err_o,
               bus.dmem_ready_o, bus.dmem_err_o, bus.imem_rdata_o, bus.dmem_rdata_o});
    end
    @(negedge clk_i);
    bus.mem_ready_i = 1'b0;
    #1;
    checks++;
    if (bus.mem_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_idle: got %b want 0", bus.mem_valid_o);
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store();
    test_contention();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/butterfly_mem_arbiter.md
# butterfly_mem_arbiter

Two-port to one-port memory arbiter for the ButterFly RV32IM core, sharing a single unified memory bus between the core's instruction-fetch port and its data port. It sits between `butterfly_core` and a single-ported SRAM or bus bridge. It registers the winning request, enforces a bounded-starvation priority policy, and guards each transaction with a ready timeout that reports a bus error to the requester.

## Interface
- `MAX_STARVE`, default 4: consecutive data grants allowed while instruction is pending before instruction is forced; legal range 1..15.
- `TIMEOUT_CYCLES`, default 256: bus cycles without `mem_ready_i` before abort; 0 disables the timeout.
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `imem_valid_i` in 1: fetch request.
- `imem_addr_i` in 32: fetch address.
- `imem_rdata_o` out 32: fetch data, valid while `imem_ready_o`.
- `imem_ready_o` out 1: fetch completion pulse.
- `imem_err_o` out 1: fetch timed out; qualifies `imem_ready_o`.
- `dmem_valid_i` in 1: data request.
- `dmem_write_i` in 1: 1 = store.
- `dmem_addr_i` in 32: data address.
- `dmem_wdata_i` in 32: store data.
- `dmem_wstrb_i` in 4: byte strobes.
- `dmem_rdata_o` out 32: load data, valid while `dmem_ready_o`.
- `dmem_ready_o` out 1: data completion pulse.
- `dmem_err_o` out 1: data timed out; qualifies `dmem_ready_o`.
- `mem_valid_o` out 1: bus request.
- `mem_write_o` out 1: bus store.
- `mem_addr_o` out 32: bus address.
- `mem_wdata_o` out 32: bus store data.
- `mem_wstrb_o` out 4: bus byte strobes.
- `mem_rdata_i` in 32: bus read data.
- `mem_ready_i` in 1: bus completion, one cycle.

## Operation
- FSM states are IDLE, BUSY_I and BUSY_D. Reset state is IDLE.
- Requester protocol: `valid` and payload are held until the matching `ready`. `ready` is a one-cycle pulse. The arbiter samples requesters only in IDLE.
- IDLE with one valid requester: latch that requester's payload into the bus output registers and go to BUSY_x.
- Instruction fetches drive `mem_write_o` = 0 and `mem_wstrb_o` = 0.
- IDLE with both requesters valid: data wins, unless `starve_cnt` == `MAX_STARVE`, in which case instruction wins.
- `starve_cnt` (4 bits):
  - increments on each data grant while `imem_valid_i` = 1;
  - clears on every instruction grant;
  - clears in any IDLE cycle where `imem_valid_i` = 0;
  - saturates at `MAX_STARVE`.
- BUSY_x: the bus outputs come from registers and stay stable. On `mem_ready_i`:
  - the granted requester's `ready` = 1 combinationally that cycle;
  - `rdata` = `mem_rdata_i`;
  - the FSM returns to IDLE.
- The non-granted requester's `ready`, `err` and `rdata` are 0.
- Timeout: `to_cnt` clears on grant and increments each BUSY cycle without `mem_ready_i`. If it reaches `TIMEOUT_CYCLES`-1 while `mem_ready_i` = 0:
  - requester `ready` = 1, `err` = 1, `rdata` = 0;
  - `mem_valid_o` drops at the next edge;
  - the FSM returns to IDLE.
- If `mem_ready_i` and the timeout condition occur in the same cycle, `mem_ready_i` wins and `err` = 0.
- Requester dropping `valid` while BUSY is a protocol violation. It is ignored; the latched transaction completes.

## Timing
- Reset values:
  - `mem_valid_o`, `mem_write_o` = 0;
  - `mem_addr_o`, `mem_wdata_o` = 0;
  - `mem_wstrb_o` = 0;
  - all requester `ready`/`err`/`rdata` = 0;
  - `starve_cnt` and `to_cnt` = 0.
- Grant latency: a request in IDLE at cycle N gives `mem_valid_o` = 1 at cycle N+1.
- Completion: `mem_ready_i` at cycle M gives requester `ready` at M, with zero added latency.
- Next `mem_valid_o` is at M+2 at the earliest. There is a one-cycle IDLE bubble between transactions.
- Best-case throughput is one transaction per 3 cycles with a 1-cycle-latency memory.
- Reset mid-transaction: at the reset edge, all outputs take reset values and any in-flight response is discarded. `mem_ready_i` arriving afterwards in IDLE is ignored.

## Configuration
- `BUTTERFLY_ARB_RR_EN` defined: round-robin replaces data priority. With both requesters valid in IDLE, the grant goes to the requester not granted last. The last-grant flag resets to "instruction", so data wins the first tie. `starve_cnt` and `MAX_STARVE` are unused.
- `BUTTERFLY_ARB_RR_EN` not defined: data priority with `MAX_STARVE` bound, exactly as in Operation.

## Test plan
- Single fetch: `imem_valid_i` with addr 0x0000_0100, memory ready after 2 cycles with 0x0000_0013. Required: `mem_valid_o` at N+1 with `mem_write_o` = 0 and `mem_wstrb_o` = 0; `imem_ready_o` pulse with `imem_rdata_o` = 0x0000_0013; `imem_err_o` = 0.
- Store: data write to 0x2000_0004, wdata 0xDEADBEEF, wstrb 0b0011. Required: bus shows identical payload held stable until ready; `dmem_ready_o` one pulse.
- Contention (macro off, `MAX_STARVE` = 4, both always valid): required grant order D,D,D,D,I,D,D,D,D,I.
- Contention (macro on): required grant order D,I,D,I.
- Timeout, `TIMEOUT_CYCLES` = 8, `mem_ready_i` held 0: required `dmem_ready_o` = 1, `dmem_err_o` = 1, `dmem_rdata_o` = 0 in the 8th BUSY cycle; `mem_valid_o` = 0 next cycle. Repeat with `mem_ready_i` in that same cycle: required `err` = 0.
- Reset asserted on the 2nd BUSY cycle: required all outputs 0 next cycle; a stale `mem_ready_i` produces no requester `ready`.
